// File: rtl/uart_tx_fifo_if.sv
// Write-side bundle of uart_tx_fifo: byte strobe from sobel_ctrl, status back.
//   pi_data  byte to send
//   pi_flag  one-cycle write strobe for pi_data
//   po_busy  frame on the line or FIFO non-empty
//   po_full  FIFO holds FIFO_DEPTH bytes
//   po_ovf   one-cycle pulse: a strobed byte was dropped (FIFO full)
interface uart_tx_fifo_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       po_busy;
  logic       po_full;
  logic       po_ovf;

  modport master (output pi_data, pi_flag, input  po_busy, po_full, po_ovf);
  modport slave  (input  pi_data, pi_flag, output po_busy, po_full, po_ovf);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter, 8N1, LSB first, with a byte FIFO in front of it.
// Return path for the sobel result stream; runs in the s_clk domain.
//   sclk   system clock
//   rst_n  asynchronous active-low reset; abandons any frame, line goes high
//   bus    write strobe/data in, busy/full/overflow status out
//   tx     serial line, idle high, registered
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic            sclk,
  input  logic            rst_n,
  uart_tx_fifo_if.slave   bus,
  output logic            tx
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shift, shift_n;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_n;
  logic [7:0]        mem [FIFO_DEPTH];

  logic full, wr_en, pop, baud_last, tx_n;

  // Full is judged on the current count, so a same-cycle pop never frees a slot.
  assign full      = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign wr_en     = bus.pi_flag & ~full;
  assign baud_last = (baud_cnt == CNT_W'(BIT_CYCLES - 1));

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin // STOP
        if (baud_last) begin
          baud_cnt_n = '0;
          if (count != '0) begin
            // back-to-back: next start bit follows the stop bit directly
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
    endcase

    // tx is registered from the next state so it changes with the state itself.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase

    case ({wr_en, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx          <= 1'b1;
      bus.po_busy <= 1'b0;
      bus.po_full <= 1'b0;
      bus.po_ovf  <= 1'b0;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      count       <= count_n;
      tx          <= tx_n;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      bus.po_busy <= (state_n != IDLE) | (count_n != '0);
      bus.po_full <= (count_n == (ADDR_W+1)'(FIFO_DEPTH));
      bus.po_ovf  <= bus.pi_flag & full;
    end
  end

  always_ff @(posedge sclk) begin
    if (wr_en) mem[wr_ptr] <= bus.pi_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int unsigned BC = 8;

  logic sclk = 1'b0;
  logic rst_n;
  logic tx_s, tx_b;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_if s_if ();
  uart_tx_fifo_if b_if ();

  uart_tx_fifo #(.CLK_FREQ(80), .BAUD(10), .FIFO_DEPTH(16), .ADDR_W(4)) u_small (
    .sclk(sclk), .rst_n(rst_n), .bus(s_if), .tx(tx_s));

  uart_tx_fifo u_big (
    .sclk(sclk), .rst_n(rst_n), .bus(b_if), .tx(tx_b));

  always #5 sclk = ~sclk;

  // Independent line receiver on the small instance: finds the falling edge,
  // samples every bit at its mid-point and queues the decoded byte.
  logic [7:0] rx_q [$];
  int bad_frames = 0;

  initial begin : monitor
    logic prev, st, sp;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge sclk);
      if (rst_n && prev && (tx_s == 1'b0)) begin
        repeat (BC/2) @(negedge sclk);
        st = tx_s;
        for (int i = 0; i < 8; i++) begin
          repeat (BC) @(negedge sclk);
          b[i] = tx_s;
        end
        repeat (BC) @(negedge sclk);
        sp = tx_s;
        if (st !== 1'b0 || sp !== 1'b1) bad_frames++;
        rx_q.push_back(b);
      end
      prev = tx_s;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required bench to finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int unsigned j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    s_if.pi_flag = 1'b0; s_if.pi_data = '0;
    b_if.pi_flag = 1'b0; b_if.pi_data = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_s); end
    checks++; if (s_if.po_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", s_if.po_busy); end
    checks++; if (s_if.po_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", s_if.po_full); end
    checks++; if (s_if.po_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", s_if.po_ovf); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_big: got %b want 1", tx_b); end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (tx_s !== 1'b1 || s_if.po_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: tx %b busy %b want 1 0", tx_s, s_if.po_busy); end
  endtask

  task automatic test_single();
    for (int c = 0; c <= 82; c++) begin
      if (c == 1) begin
        checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL single_tx_c1: got %b want 1", tx_s); end
        checks++; if (s_if.po_busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1: got %b want 1", s_if.po_busy); end
      end
      if (c == 2) begin
        checks++; if (tx_s !== 1'b0) begin errors++; $display("FAIL single_start_fall: got %b want 0", tx_s); end
      end
      if (c >= 2 && c < 82 && ((c - 2) % BC) == BC/2) begin
        checks++;
        if (tx_s !== exp_bit(8'hA5, (c - 2) / BC)) begin
          errors++; $display("FAIL single_bit%0d: got %b want %b", (c - 2) / BC, tx_s, exp_bit(8'hA5, (c - 2) / BC));
        end
      end
      if (c == 81) begin
        checks++; if (s_if.po_busy !== 1'b1) begin errors++; $display("FAIL single_busy_last_stop: got %b want 1", s_if.po_busy); end
      end
      if (c == 82) begin
        checks++; if (s_if.po_busy !== 1'b0 || tx_s !== 1'b1) begin
          errors++; $display("FAIL single_end: busy %b tx %b want 0 1", s_if.po_busy, tx_s); end
      end
      s_if.pi_flag = (c == 0);
      s_if.pi_data = (c == 0) ? 8'hA5 : 8'h5A;
      step();
    end
    s_if.pi_flag = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int ovf_seen, busy_drop;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    ovf_seen = 0; busy_drop = 0;
    for (int c = 0; c <= 242; c++) begin
      if (c >= 1) begin
        if (s_if.po_ovf !== 1'b0) ovf_seen++;
        if (c <= 241 && s_if.po_busy !== 1'b1) busy_drop++;
      end
      if (c >= 2 && c < 242 && ((c - 2) % BC) == BC/2) begin
        checks++;
        if (tx_s !== exp_bit(bytes[(c - 2) / 80], ((c - 2) % 80) / BC)) begin
          errors++; $display("FAIL b2b_frame%0d_bit%0d: got %b want %b", (c - 2) / 80, ((c - 2) % 80) / BC,
                              tx_s, exp_bit(bytes[(c - 2) / 80], ((c - 2) % 80) / BC));
        end
      end
      if (c == 242) begin
        checks++; if (s_if.po_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", s_if.po_busy); end
      end
      s_if.pi_flag = (c <= 2);
      s_if.pi_data = (c <= 2) ? bytes[c] : 8'hC3;
      step();
    end
    s_if.pi_flag = 1'b0;
    checks++; if (ovf_seen != 0) begin errors++; $display("FAIL b2b_ovf: got %0d pulses want 0", ovf_seen); end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL b2b_busy_gap: got %0d low cycles want 0", busy_drop); end
  endtask

  // 17 strobes fill the FIFO (one byte already in flight), the 18th overflows;
  // then a strobe collides with the STOP-end pop while full.
  task automatic test_overflow();
    logic [7:0] exp [$];
    rx_q.delete();
    bad_frames = 0;
    for (int i = 0; i < 17; i++) begin
      s_if.pi_flag = 1'b1; s_if.pi_data = 8'h10 + 8'(i);
      exp.push_back(8'h10 + 8'(i));
      step();
    end
    // cycle N+17
    checks++; if (s_if.po_full !== 1'b1) begin errors++; $display("FAIL ovf_full_after17: got %b want 1", s_if.po_full); end
    checks++; if (s_if.po_ovf !== 1'b0) begin errors++; $display("FAIL ovf_no_pulse_yet: got %b want 0", s_if.po_ovf); end
    s_if.pi_data = 8'hEE;
    step();
    s_if.pi_flag = 1'b0;
    checks++; if (s_if.po_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", s_if.po_ovf); end
    step();
    checks++; if (s_if.po_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b want 0", s_if.po_ovf); end
    checks++; if (s_if.po_full !== 1'b1) begin errors++; $display("FAIL ovf_still_full: got %b want 1", s_if.po_full); end
    repeat (62) step();
    // cycle N+81: last stop cycle of the first frame, pop happens now
    s_if.pi_flag = 1'b1; s_if.pi_data = 8'hDD;
    step();
    s_if.pi_data = 8'h77;
    exp.push_back(8'h77);
    checks++; if (s_if.po_ovf !== 1'b1) begin errors++; $display("FAIL collide_ovf: got %b want 1", s_if.po_ovf); end
    checks++; if (s_if.po_full !== 1'b0) begin errors++; $display("FAIL collide_full_drop: got %b want 0", s_if.po_full); end
    step();
    s_if.pi_flag = 1'b0;
    checks++; if (s_if.po_ovf !== 1'b0) begin errors++; $display("FAIL refill_ovf: got %b want 0", s_if.po_ovf); end
    checks++; if (s_if.po_full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b want 1", s_if.po_full); end
    repeat (1370) step();
    checks++; if (rx_q.size() != exp.size()) begin
      errors++; $display("FAIL ovf_frame_count: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin
        errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp[i]); end
    end
    checks++; if (bad_frames != 0) begin errors++; $display("FAIL ovf_framing: got %0d bad frames want 0", bad_frames); end
    checks++; if (s_if.po_busy !== 1'b0) begin errors++; $display("FAIL ovf_drained_busy: got %b want 0", s_if.po_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int tx_low, busy_high;
    for (int c = 0; c < 37; c++) begin
      s_if.pi_flag = (c <= 5);
      s_if.pi_data = (c == 0) ? 8'h00 : 8'h40 + 8'(c);
      step();
    end
    s_if.pi_flag = 1'b0;
    // cycle N+37: inside data bit 3 of 8'h00, line is low
    checks++; if (tx_s !== 1'b0) begin errors++; $display("FAIL midframe_pre_tx: got %b want 0", tx_s); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b want 1", tx_s); end
    checks++; if (s_if.po_busy !== 1'b0) begin errors++; $display("FAIL midframe_reset_busy: got %b want 0", s_if.po_busy); end
    checks++; if (s_if.po_full !== 1'b0 || s_if.po_ovf !== 1'b0) begin
      errors++; $display("FAIL midframe_reset_flags: full %b ovf %b want 0 0", s_if.po_full, s_if.po_ovf); end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (100) step();
    rx_q.delete();
    tx_low = 0; busy_high = 0;
    for (int c = 0; c < 800; c++) begin
      if (tx_s !== 1'b1) tx_low++;
      if (s_if.po_busy !== 1'b0) busy_high++;
      step();
    end
    checks++; if (tx_low != 0) begin errors++; $display("FAIL after_reset_tx_quiet: got %0d low cycles want 0", tx_low); end
    checks++; if (busy_high != 0) begin errors++; $display("FAIL after_reset_busy: got %0d busy cycles want 0", busy_high); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL after_reset_frames: got %0d want 0", rx_q.size()); end
  endtask

  // 8'h55 toggles the line at every bit boundary, so edges give each bit length.
  task automatic test_default_baud();
    int unsigned edges [12];
    int n_edges;
    logic prev;
    for (int k = 0; k < 12; k++) edges[k] = 0;
    n_edges = 0;
    prev = tx_b;
    for (int c = 0; c <= 52082; c++) begin
      if (c >= 1 && tx_b !== prev) begin
        if (n_edges < 12) edges[n_edges] = c;
        n_edges++;
        prev = tx_b;
      end
      if (c == 52081) begin
        checks++; if (b_if.po_busy !== 1'b1) begin errors++; $display("FAIL big_busy_last_stop: got %b want 1", b_if.po_busy); end
      end
      if (c == 52082) begin
        checks++; if (b_if.po_busy !== 1'b0) begin errors++; $display("FAIL big_busy_end: got %b want 0", b_if.po_busy); end
      end
      b_if.pi_flag = (c == 0);
      b_if.pi_data = (c == 0) ? 8'h55 : 8'hAA;
      step();
    end
    b_if.pi_flag = 1'b0;
    checks++; if (n_edges != 10) begin errors++; $display("FAIL big_edge_count: got %0d want 10", n_edges); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (edges[k] != 2 + 5208 * k) begin
        errors++; $display("FAIL big_edge%0d: got cycle %0d want %0d", k, edges[k], 2 + 5208 * k); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_default_baud();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
